flash_reader: RTL and testbench

FLASH_READER -- requirements
Module: flash_reader

---
 rtl/flash_reader.sv | 147 ++++++++++++++
 tb/tb_flash_reader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/flash_reader.sv
// SPI flash byte reader: issues a READ (0x03) command with a 24-bit address and
// returns the first data byte, using SPI mode 0 with all outputs registered.
module flash_reader #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fd_valid,
  input  logic [23:0] fd_address,
  output logic        fd_ready,
  output logic [7:0]  fd,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSetup = 3'd1,
    StShift = 3'd2,
    StHold  = 3'd3,
    StDone  = 3'd4,
    StGap   = 3'd5
  } state_e;

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
  localparam logic [7:0] GapLast = 8'(CS_GAP - 1);

  state_e      r_state;
  logic [7:0]  r_cnt;
  logic [5:0]  r_bit;
  logic [39:0] r_frame;
  logic [7:0]  r_data;
  logic [7:0]  r_fd;
  logic        r_ready;
  logic        r_cs_n;
  logic        r_sck;
  logic        r_mosi;
  logic [39:0] w_frame;

  // Command and address fill the top 32 bits; the low byte keeps mosi at 0 while data returns.
  assign w_frame = {8'h03, fd_address, 8'h00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= 8'd0;
      r_bit   <= 6'd0;
      r_frame <= 40'd0;
      r_data  <= 8'h00;
      r_fd    <= 8'h00;
      r_ready <= 1'b0;
      r_cs_n  <= 1'b1;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_cs_n  <= 1'b1;
          r_sck   <= 1'b0;
          r_mosi  <= 1'b0;
          r_ready <= 1'b0;
          r_cnt   <= 8'd0;
          if (fd_valid) begin
            r_frame <= w_frame;
            r_mosi  <= w_frame[39];
            r_cs_n  <= 1'b0;
            r_state <= StSetup;
          end
        end
        StSetup: begin
          if (r_cnt == DivLast) begin
            r_cnt   <= 8'd0;
            r_bit   <= 6'd0;
            r_sck   <= 1'b1;
            r_state <= StShift;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        StShift: begin
          if (r_cnt != DivLast) begin
            r_cnt <= r_cnt + 8'd1;
          end else begin
            r_cnt <= 8'd0;
            if (r_sck) begin
              r_sck   <= 1'b0;
              r_mosi  <= r_frame[38];
              r_frame <= {r_frame[38:0], 1'b0};
            end else if (r_bit == 6'd39) begin
              r_state <= StHold;
            end else begin
              r_sck <= 1'b1;
              r_bit <= r_bit + 6'd1;
              // Rising edges 33..40 carry the data byte.
              if (r_bit >= 6'd31) begin
                r_data <= {r_data[6:0], spi_miso};
              end
            end
          end
        end
        StHold: begin
          if (r_cnt == DivLast) begin
            r_cnt   <= 8'd0;
            r_cs_n  <= 1'b1;
            r_fd    <= r_data;
            r_ready <= 1'b1;
            r_state <= StDone;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        StDone: begin
          r_ready <= 1'b0;
          r_cnt   <= 8'd0;
          r_state <= StGap;
        end
        StGap: begin
          if (r_cnt == GapLast) begin
            r_cnt   <= 8'd0;
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_cnt   <= 8'd0;
          r_bit   <= 6'd0;
          r_ready <= 1'b0;
          r_cs_n  <= 1'b1;
          r_sck   <= 1'b0;
          r_mosi  <= 1'b0;
        end
      endcase
    end
  end

  assign fd_ready = r_ready;
  assign fd       = r_fd;
  assign spi_cs_n = r_cs_n;
  assign spi_sck  = r_sck;
  assign spi_mosi = r_mosi;

endmodule

// File: tb/tb_flash_reader.sv
// Directed bench for flash_reader: a default instance plus a CLK_DIV=1/CS_GAP=1 instance,
// each with a small SPI flash model driving miso.
module tb_flash_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fd_valid = 1'b0;
  logic [23:0] fd_address = 24'h0;
  logic        fd_ready;
  logic [7:0]  fd;
  logic        spi_cs_n, spi_sck, spi_mosi;
  logic        spi_miso = 1'b0;

  logic        fd_valid_f = 1'b0;
  logic [23:0] fd_address_f = 24'h0;
  logic        fd_ready_f;
  logic [7:0]  fd_f;
  logic        spi_cs_n_f, spi_sck_f, spi_mosi_f;
  logic        spi_miso_f = 1'b0;

  flash_reader u_dut (
    .clk        (clk),
    .rst        (rst),
    .fd_valid   (fd_valid),
    .fd_address (fd_address),
    .fd_ready   (fd_ready),
    .fd         (fd),
    .spi_cs_n   (spi_cs_n),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso)
  );

  flash_reader #(.CLK_DIV(1), .CS_GAP(1)) u_dut_fast (
    .clk        (clk),
    .rst        (rst),
    .fd_valid   (fd_valid_f),
    .fd_address (fd_address_f),
    .fd_ready   (fd_ready_f),
    .fd         (fd_f),
    .spi_cs_n   (spi_cs_n_f),
    .spi_sck    (spi_sck_f),
    .spi_mosi   (spi_mosi_f),
    .spi_miso   (spi_miso_f)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Flash model and frame monitor for the default instance.
  logic [7:0]  miso_q[$];
  logic [7:0]  cur_byte = 8'h00;
  int          rise_n = 0, fall_n = 0, tail_bad = 0;
  logic [31:0] mosi_word = 32'h0;
  int          hi_cnt = 0, last_gap = 0, ready_cnt = 0;

  always @(negedge spi_cs_n) begin
    rise_n = 0; fall_n = 0; tail_bad = 0; mosi_word = 32'h0;
    if (miso_q.size() > 0) cur_byte = miso_q.pop_front();
  end

  always @(posedge spi_sck) begin
    rise_n++;
    if (rise_n <= 32) mosi_word = {mosi_word[30:0], spi_mosi};
    else if (spi_mosi !== 1'b0) tail_bad++;
  end

  always @(negedge spi_sck) begin
    fall_n++;
    if (fall_n >= 32 && fall_n <= 39) spi_miso = cur_byte[39 - fall_n];
  end

  always @(negedge clk) begin
    if (spi_cs_n) hi_cnt++;
    else if (hi_cnt != 0) begin
      last_gap = hi_cnt;
      hi_cnt = 0;
    end
    if (fd_ready) ready_cnt++;
  end

  // Flash model and SCK period tracker for the fast instance.
  logic [7:0] f_byte = 8'h00;
  int         f_fall = 0, f_last_rise = -1, f_per_min = 1000, f_per_max = 0;
  logic       f_sck_prev = 1'b0;

  always @(negedge spi_cs_n_f) begin
    f_fall = 0; f_last_rise = -1; f_per_min = 1000; f_per_max = 0;
  end

  always @(negedge spi_sck_f) begin
    f_fall++;
    if (f_fall >= 32 && f_fall <= 39) spi_miso_f = f_byte[39 - f_fall];
  end

  always @(negedge clk) begin
    if (spi_sck_f && !f_sck_prev) begin
      if (f_last_rise >= 0) begin
        if (cyc - f_last_rise < f_per_min) f_per_min = cyc - f_last_rise;
        if (cyc - f_last_rise > f_per_max) f_per_max = cyc - f_last_rise;
      end
      f_last_rise = cyc;
    end
    f_sck_prev = spi_sck_f;
  end

  task automatic wait_ready(input string tag, input int start, input int exp_idx);
    int idx = -1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (fd_ready) begin
        idx = cyc - start;
        break;
      end
    end
    check_eq(tag, 32'(idx), 32'(exp_idx));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cs_n"}, 32'(spi_cs_n), 32'd1);
    check_eq({tag, "_sck"}, 32'(spi_sck), 32'd0);
    check_eq({tag, "_mosi"}, 32'(spi_mosi), 32'd0);
    check_eq({tag, "_fd"}, 32'(fd), 32'h00);
    check_eq({tag, "_ready"}, 32'(fd_ready), 32'd0);
  endtask

  initial begin
    int start;
    int rc0;
    int fidx;

    // Reset asserted without any clock edge in between.
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst0");
    check_eq("rst0_cs_n_fast", 32'(spi_cs_n_f), 32'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single read right after reset release.
    miso_q.push_back(8'hA5);
    fd_address = 24'h012345; fd_valid = 1'b1; start = cyc;
    @(posedge clk); #1 fd_valid = 1'b0;
    wait_ready("t1_latency", start, 165);
    check_eq("t1_fd", 32'(fd), 32'hA5);
    check_eq("t1_cs_n_done", 32'(spi_cs_n), 32'd1);
    check_eq("t1_mosi", mosi_word, 32'h03012345);
    check_eq("t1_mosi_tail", 32'(tail_bad), 32'd0);
    @(negedge clk);
    check_eq("t1_ready_pulse", 32'(fd_ready), 32'd0);
    check_eq("t1_fd_hold", 32'(fd), 32'hA5);
    repeat (10) @(posedge clk);

    // Back-to-back reads with fd_valid held high.
    #1 miso_q.push_back(8'h3C); miso_q.push_back(8'hC3);
    fd_address = 24'h000000; fd_valid = 1'b1; start = cyc;
    @(posedge clk); #1 fd_address = 24'hFFFFFF;
    wait_ready("t2_latency1", start, 165);
    check_eq("t2_fd1", 32'(fd), 32'h3C);
    check_eq("t2_mosi1", mosi_word, 32'h03000000);
    wait_ready("t2_latency2", start, 335);
    fd_valid = 1'b0;
    check_eq("t2_fd2", 32'(fd), 32'hC3);
    check_eq("t2_mosi2", mosi_word, 32'h03FFFFFF);
    check_eq("t2_gap", 32'(last_gap), 32'd6);
    repeat (10) @(negedge clk);
    check_eq("t2_no_third", 32'(spi_cs_n), 32'd1);
    @(posedge clk);

    // Request held one cycle, address changed mid-frame.
    #1 miso_q.push_back(8'h5A);
    fd_address = 24'hABCDEF; fd_valid = 1'b1; start = cyc;
    @(posedge clk); #1 fd_valid = 1'b0;
    while (cyc - start < 20) @(posedge clk);
    #1 fd_address = 24'h00FFFF;
    wait_ready("t3_latency", start, 165);
    check_eq("t3_mosi", mosi_word, 32'h03ABCDEF);
    check_eq("t3_fd", 32'(fd), 32'h5A);
    repeat (10) @(posedge clk);

    // Reset during the address phase, then a fresh request.
    #1 miso_q.push_back(8'h99);
    fd_address = 24'h112233; fd_valid = 1'b1; start = cyc;
    @(posedge clk); #1 fd_valid = 1'b0;
    while (cyc - start < 40) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    rc0 = ready_cnt;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    miso_q.push_back(8'h66);
    fd_address = 24'h0A0B0C; fd_valid = 1'b1; start = cyc;
    @(posedge clk); #1 fd_valid = 1'b0;
    wait_ready("t4_latency", start, 165);
    check_eq("t4_mosi", mosi_word, 32'h030A0B0C);
    check_eq("t4_fd", 32'(fd), 32'h66);
    @(negedge clk);
    check_eq("t4_ready_count", 32'(ready_cnt - rc0), 32'd1);
    @(posedge clk);

    // Fast instance: CLK_DIV=1, CS_GAP=1.
    #1 f_byte = 8'h7E;
    fd_address_f = 24'h5555AA; fd_valid_f = 1'b1; start = cyc;
    @(posedge clk); #1 fd_valid_f = 1'b0;
    fidx = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (fd_ready_f) begin
        fidx = cyc - start;
        break;
      end
    end
    check_eq("t5_latency", 32'(fidx), 32'd83);
    check_eq("t5_fd", 32'(fd_f), 32'h7E);
    check_eq("t5_sck_per_min", 32'(f_per_min), 32'd2);
    check_eq("t5_sck_per_max", 32'(f_per_max), 32'd2);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
